uart_rx_os: RTL and testbench



---
 rtl/uart_rx_os.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with a status-tagged RX FIFO.
//   clk, rst        : single clock, synchronous active-high reset
//   enable          : receiver enable (low holds tick counter, aborts frame)
//   div             : one oversample tick every div+1 clocks
//   data_bits       : 0..3 selects 5..8 data bits
//   parity_en/odd   : parity bit present / odd (1) or even (0)
//   rx_wm, timeout  : watermark level and idle bit-times (0 disables each)
//   ovr_clr         : clears the sticky overrun flag
//   uart_rx         : asynchronous serial input
//   rd_*            : first-word fall-through FIFO head, popped on valid&&ready
//   level           : FIFO occupancy
//   wm_irq, timeout_irq, overrun : status outputs
module uart_rx_os #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int OSR        = 16,
  parameter int N_SYNC     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          div,
  input  logic [1:0]                    data_bits,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic [$clog2(FIFO_DEPTH):0]   rx_wm,
  input  logic [7:0]                    timeout,
  input  logic                          ovr_clr,
  input  logic                          uart_rx,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [7:0]                    rd_data,
  output logic                          rd_perr,
  output logic                          rd_ferr,
  output logic                          rd_brk,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          wm_irq,
  output logic                          timeout_irq,
  output logic                          overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(OSR);
  localparam int IW = $clog2(256 * OSR);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  // ---------------- synchroniser ----------------
  logic [N_SYNC-1:0] sync_q;
  logic              rx_s;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[N_SYNC-2:0], uart_rx};
  end
  assign rx_s = sync_q[N_SYNC-1];

  // ---------------- oversample tick ----------------
  logic [DIV_WIDTH-1:0] tcnt;
  logic                 tick;

  assign tick = enable && (tcnt == div);

  always_ff @(posedge clk) begin
    if (rst || !enable)  tcnt <= '0;
    else if (tcnt == div) tcnt <= '0;
    else                  tcnt <= tcnt + DIV_WIDTH'(1);
  end

  // ---------------- receive FSM ----------------
  state_t        state, state_nxt;
  logic [OW-1:0] os_cnt;
  logic          s_a, s_b;
  logic [3:0]    bit_idx;
  logic [7:0]    data_q;
  logic          pbit_q;
  logic          vote, vote_pt, bit_end;
  logic [3:0]    nbits;
  logic          brk, perr, push;
  logic [10:0]   push_word;

  assign vote_pt = tick && (os_cnt == OW'(OSR/2 + 1));
  assign bit_end = tick && (os_cnt == OW'(OSR - 1));
  // Third sample is the live line value at the resolve tick.
  assign vote    = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
  assign nbits   = {2'b00, data_bits} + 4'd5;
  assign brk     = (data_q == 8'h00) && (!pbit_q || !parity_en) && !vote;
  assign perr    = parity_en && ((^data_q ^ pbit_q) != parity_odd);
  assign push    = (state == STOP) && vote_pt;
  // A break always has a low stop bit, so ferr is already set for it.
  assign push_word = {brk, ~vote, perr, data_q};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) state_nxt = IDLE;
    else begin
      unique case (state)
        IDLE:     if (tick && !rx_s) state_nxt = START;
        START:    if (vote_pt && vote) state_nxt = IDLE;
                  else if (bit_end)    state_nxt = DATA;
        // >= keeps the FSM moving if data_bits shrinks mid-frame.
        DATA:     if (bit_end && bit_idx >= nbits)
                    state_nxt = parity_en ? PARITY : STOP;
        PARITY:   if (bit_end) state_nxt = STOP;
        // Early return at the stop vote lets the next start edge be caught.
        STOP:     if (vote_pt) state_nxt = brk ? BRK_WAIT : IDLE;
        BRK_WAIT: if (rx_s) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      os_cnt  <= '0;
      s_a     <= 1'b1;
      s_b     <= 1'b1;
      bit_idx <= '0;
      data_q  <= '0;
      pbit_q  <= 1'b0;
    end else begin
      // The detecting tick counts as sample 0 of the start bit.
      if (state == IDLE)  os_cnt <= (tick && !rx_s) ? OW'(1) : '0;
      else if (tick)      os_cnt <= (os_cnt == OW'(OSR - 1)) ? '0 : os_cnt + OW'(1);

      if (tick && os_cnt == OW'(OSR/2 - 1)) s_a <= rx_s;
      if (tick && os_cnt == OW'(OSR/2))     s_b <= rx_s;

      if (state == IDLE) begin
        bit_idx <= '0;
        data_q  <= '0;
        pbit_q  <= 1'b0;
      end else begin
        if (state == DATA && vote_pt) begin
          if (bit_idx < 4'd8) data_q[bit_idx[2:0]] <= vote;
          bit_idx <= bit_idx + 4'd1;
        end
        if (state == PARITY && vote_pt) pbit_q <= vote;
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level_q;
  logic          full, pop, wr, ovf;
  logic [10:0]   head;

  assign full = (level_q == (AW+1)'(FIFO_DEPTH));
  assign pop  = rd_valid && rd_ready;
  assign wr   = push && (!full || pop);
  assign ovf  = push && full && !pop;
  assign head = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      unique case ({wr, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
      // A fresh overrun beats a simultaneous clear.
      if (ovf)          overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  assign rd_valid = (level_q != '0);
  assign level    = level_q;
  assign rd_data  = rd_valid ? head[7:0] : 8'h00;
  assign rd_perr  = rd_valid && head[8];
  assign rd_ferr  = rd_valid && head[9];
  assign rd_brk   = rd_valid && head[10];
  assign wm_irq   = (rx_wm != '0) && (level_q >= rx_wm);

  // ---------------- idle timeout ----------------
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] to_lim;

  assign to_lim = IW'(timeout) * IW'(OSR);

  always_ff @(posedge clk) begin
    if (rst || push || pop || level_q == '0) idle_cnt <= '0;
    else if (state == IDLE && tick && idle_cnt != '1) idle_cnt <= idle_cnt + IW'(1);
  end

  assign timeout_irq = (timeout != 8'd0) && (idle_cnt >= to_lim);
endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;
  localparam int FD  = 4;
  localparam int DW  = 16;
  localparam int OSR = 16;
  localparam int LW  = $clog2(FD) + 1;

  logic          clk, rst, enable, parity_en, parity_odd, ovr_clr, uart_rx;
  logic [DW-1:0] div;
  logic [1:0]    data_bits;
  logic [LW-1:0] rx_wm, level;
  logic [7:0]    timeout, rd_data;
  logic          rd_valid, rd_ready, rd_perr, rd_ferr, rd_brk;
  logic          wm_irq, timeout_irq, overrun;

  uart_rx_os #(.FIFO_DEPTH(FD), .DIV_WIDTH(DW), .OSR(OSR), .N_SYNC(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .div(div), .data_bits(data_bits),
    .parity_en(parity_en), .parity_odd(parity_odd), .rx_wm(rx_wm),
    .timeout(timeout), .ovr_clr(ovr_clr), .uart_rx(uart_rx),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_perr(rd_perr), .rd_ferr(rd_ferr), .rd_brk(rd_brk), .level(level),
    .wm_irq(wm_irq), .timeout_irq(timeout_irq), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [10:0] ent_t;   // {brk, ferr, perr, data}
  ent_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ready_mode = 0;         // 0 hold low, 1 random, 2 always
  int   cur_div = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Frame rules: LSB-first data masked to width, parity over data+pbit,
  // stop bit low = framing error, all-low frame with low stop = break.
  function automatic ent_t model(input logic [7:0] d, input int nb, input bit pe,
                                 input bit po, input bit pb, input bit stp);
    int   mask;
    logic [7:0] m;
    bit   perr, brk;
    mask = (1 << nb) - 1;
    m    = d & mask[7:0];
    perr = pe && (((($countones(m) + int'(pb)) % 2) != 0) != po);
    brk  = (m == 8'h00) && (!pe || !pb) && !stp;
    return {brk, !stp, perr, m};
  endfunction

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat ((cur_div + 1) * OSR) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pe, input bit po,
                            input bit pb, input bit stp, input int gap);
    data_bits  = 2'(nb - 5);
    parity_en  = pe;
    parity_odd = po;
    // Expected entry is queued before the DUT can push; a full model FIFO drops it.
    if (exp_q.size() < FD) exp_q.push_back(model(d, nb, pe, po, pb, stp));
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pe) drive_bit(pb);
    drive_bit(stp);
    uart_rx = 1'b1;
    repeat (gap * (cur_div + 1) * OSR) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    ready_mode = 2;
    n = 0;
    @(negedge clk);
    while (rd_valid && n < 50) begin @(negedge clk); n++; end
    ready_mode = 0;
    if (rd_valid) begin
      checks++; failures++;
      $display("FAIL drain_timeout level=%0d expected=0", level);
    end
  endtask

  task automatic pop_one();
    ready_mode = 2;
    @(posedge clk); #2;
    ready_mode = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_div(input int d);
    enable = 1'b0;
    cur_div = d;
    div = DW'(d);
    @(posedge clk); #1;
    enable = 1'b1;
  endtask

  // rd_ready driver
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       rd_ready = 1'($urandom_range(0, 1));
        2:       rd_ready = 1'b1;
        default: rd_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: every pop is checked against the queued expectation.
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_pop actual=%0h expected=none", {rd_brk, rd_ferr, rd_perr, rd_data});
      end else begin
        chk("pop_entry", 32'({rd_brk, rd_ferr, rd_perr, rd_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] d;
    int nb;
    bit pe, po, pb, stp;

    rst = 1'b1; enable = 1'b0; div = '0; data_bits = 2'd3; parity_en = 1'b0;
    parity_odd = 1'b0; rx_wm = '0; timeout = 8'd0; ovr_clr = 1'b0; uart_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_wm_irq", 32'(wm_irq), 0);
    chk("rst_timeout_irq", 32'(timeout_irq), 0);
    chk("rst_overrun", 32'(overrun), 0);
    enable = 1'b1;
    repeat (5) @(posedge clk); #1;

    // 8N1 0x55 with rd_valid latency from the start edge
    n = 0;
    fork
      send_frame(8'h55, 8, 0, 0, 0, 1, 1);
      begin
        @(posedge clk);
        n = 0;
        while (n < 2000) begin
          @(negedge clk);
          if (rd_valid) break;
          @(posedge clk);
          n++;
        end
      end
    join
    chk("rx55_latency", 32'(n), 156);
    chk("rx55_level", 32'(level), 1);
    drain();

    // parity cases
    ready_mode = 2;
    send_frame(8'h53, 8, 1, 1, 1, 1, 1);
    send_frame(8'h53, 8, 1, 1, 0, 1, 1);
    send_frame(8'h1F, 5, 1, 0, 1, 1, 1);
    drain();

    // false start: 6-clock glitch
    ready_mode = 2;
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (6) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (3 * OSR) @(posedge clk);
    @(negedge clk);
    chk("false_start_level", 32'(level), 0);
    send_frame(8'hA7, 8, 0, 0, 0, 1, 1);

    // break: 20 bit-times low, then a normal char
    data_bits = 2'd3; parity_en = 1'b0;
    exp_q.push_back(model(8'h00, 8, 0, 0, 0, 0));
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (20 * OSR) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (3 * OSR) @(posedge clk); #1;
    send_frame(8'h41, 8, 0, 0, 0, 1, 1);
    drain();
    chk("brk_all_seen", 32'(exp_q.size()), 0);

    // enable dropped mid-frame: partial char discarded, no lock-up
    ready_mode = 2;
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (3 * OSR) @(posedge clk);
    #1 enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 enable = 1'b1;
    repeat (12 * OSR) @(posedge clk);
    @(negedge clk);
    chk("en_drop_level", 32'(level), 0);
    send_frame(8'h96, 8, 0, 0, 0, 1, 1);
    drain();

    // overrun
    ready_mode = 0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("ovr_level", 32'(level), 4);
    chk("ovr_flag", 32'(overrun), 1);
    @(posedge clk); #1 ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", 32'(overrun), 0);
    drain();
    chk("ovr_drained", 32'(level), 0);

    // watermark
    rx_wm = LW'(2);
    send_frame(8'h11, 8, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("wm_one", 32'(wm_irq), 0);
    send_frame(8'h22, 8, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("wm_two", 32'(wm_irq), 1);
    pop_one();
    chk("wm_pop_level", 32'(level), 1);
    chk("wm_pop", 32'(wm_irq), 0);
    drain();
    rx_wm = '0;

    // idle timeout
    timeout = 8'd2;
    n = 0;
    fork
      send_frame(8'h3C, 8, 0, 0, 0, 1, 4);
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!rd_valid && w < 2000) begin @(negedge clk); w++; end
        n = 0;
        while (n < 200) begin
          @(posedge clk); n++;
          @(negedge clk);
          if (timeout_irq) break;
        end
      end
    join
    chk("timeout_ticks", 32'(n), 32);
    pop_one();
    chk("timeout_cleared", 32'(timeout_irq), 0);
    timeout = 8'd0;

    // randomized frames with random pop pressure
    ready_mode = 1;
    for (int k = 0; k < 40; k++) begin
      set_div(int'($urandom_range(0, 2)));
      nb  = int'($urandom_range(5, 8));
      d   = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      pe  = 1'($urandom_range(0, 1));
      po  = 1'($urandom_range(0, 1));
      pb  = 1'($urandom_range(0, 1));
      stp = ($urandom_range(0, 7) != 0);
      send_frame(d, nb, pe, po, pb, stp, 2);
    end
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    chk("final_no_overrun", 32'(overrun), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
